// File: rtl/address_exception_checker.sv
// rtl/address_exception_checker.sv - first-fault fetch/load/store address checker (optional ADDR_EXC_MISALIGN_EN adds alignment checks)
module address_exception_checker #(
    parameter int ADDR_W     = 32,
    parameter int INST_LIMIT = 2047,
    parameter int DATA_LIMIT = 2047,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exception_sig,
    input  logic              mret_sig,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              mem_valid,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              address_exception,
    output logic [3:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_tval,
    output logic [CNT_W-1:0]  fault_cnt
);

    typedef enum logic {S_IDLE, S_PENDING} state_t;

    // Limits widened by one bit so they compare against carry-extended sums
    localparam logic [ADDR_W:0] INST_LIM = (ADDR_W+1)'(INST_LIMIT);
    localparam logic [ADDR_W:0] DATA_LIM = (ADDR_W+1)'(DATA_LIMIT);

    state_t            state_q, state_d;
    logic              exc_q, exc_d;
    logic [3:0]        cause_q, cause_d;
    logic [ADDR_W-1:0] tval_q, tval_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [1:0]        last_off;
    logic [ADDR_W:0]   mem_end;
    logic              if_mis, if_acc, mem_mis, mem_acc;
    logic              fault;
    logic [3:0]        fault_cause;
    logic [ADDR_W-1:0] fault_tval;
    logic              clear;

    // Offset of the last byte touched by the load/store (size 11 acts as word)
    always_comb begin
        last_off = 2'd3;
        case (mem_size)
            2'b00:   last_off = 2'd0;
            2'b01:   last_off = 2'd1;
            default: last_off = 2'd3;
        endcase
    end

    // End address carries into bit ADDR_W so wrap past the top is a bounds fault
    assign mem_end = {1'b0, mem_addr} + {{(ADDR_W-1){1'b0}}, last_off};
    assign if_acc  = ({1'b0, if_addr} > INST_LIM);
    assign mem_acc = (mem_end > DATA_LIM);

`ifdef ADDR_EXC_MISALIGN_EN
    assign if_mis  = |if_addr[1:0];
    assign mem_mis = ((mem_size == 2'b01) && mem_addr[0]) ||
                     (mem_size[1] && (|mem_addr[1:0]));
`else
    assign if_mis  = 1'b0;
    assign mem_mis = 1'b0;
`endif

    assign clear = exception_sig | mret_sig;

    // Prioritised fault selection: fetch before load/store, misaligned before bounds
    always_comb begin
        fault       = 1'b1;
        fault_cause = 4'd0;
        fault_tval  = if_addr;
        if (if_valid && if_mis) begin
            fault_cause = 4'd0;
        end else if (if_valid && if_acc) begin
            fault_cause = 4'd1;
        end else if (mem_valid && mem_mis) begin
            fault_cause = mem_we ? 4'd6 : 4'd4;
            fault_tval  = mem_addr;
        end else if (mem_valid && mem_acc) begin
            fault_cause = mem_we ? 4'd7 : 4'd5;
            fault_tval  = mem_addr;
        end else begin
            fault = 1'b0;
        end
    end

    // Next-state logic: capture first fault in IDLE, hold until trap entry/return
    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!clear && fault) begin
                    state_d = S_PENDING;
                    exc_d   = 1'b1;
                    cause_d = fault_cause;
                    tval_d  = fault_tval;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PENDING: begin
                if (clear) begin
                    state_d = S_IDLE;
                    exc_d   = 1'b0;
                    cause_d = 4'd0;
                    tval_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            exc_q   <= 1'b0;
            cause_q <= 4'd0;
            tval_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            cnt_q   <= cnt_d;
        end
    end

    assign address_exception = exc_q;
    assign exc_cause         = cause_q;
    assign exc_tval          = tval_q;
    assign fault_cnt         = cnt_q;

endmodule

// File: tb/tb_address_exception_checker.sv
// tb/tb_address_exception_checker.sv - vector-table bench for address_exception_checker
module tb_address_exception_checker;

`ifdef ADDR_EXC_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, exception_sig, mret_sig;
    logic        if_valid, mem_valid, mem_we;
    logic [31:0] if_addr, mem_addr;
    logic [1:0]  mem_size;
    logic        address_exception;
    logic [3:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [7:0]  fault_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    address_exception_checker #(
        .ADDR_W(32), .INST_LIMIT(2047), .DATA_LIMIT(2047), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .exception_sig(exception_sig), .mret_sig(mret_sig),
        .if_valid(if_valid), .if_addr(if_addr), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_size(mem_size), .mem_addr(mem_addr), .address_exception(address_exception),
        .exc_cause(exc_cause), .exc_tval(exc_tval), .fault_cnt(fault_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_v;
        logic [31:0] if_a;
        logic        mv;
        logic        mwe;
        logic [1:0]  msz;
        logic [31:0] ma;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(logic iv, logic [31:0] ia, logic mv, logic mwe, logic [1:0] msz,
                                logic [31:0] ma, logic exc, logic [3:0] cause, logic [31:0] tval);
        vec_t v;
        v.if_v = iv; v.if_a = ia; v.mv = mv; v.mwe = mwe; v.msz = msz; v.ma = ma;
        v.exc = exc; v.cause = cause; v.tval = tval;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic e, input logic [3:0] c, input logic [31:0] t);
        chk({nm, ".exc"}, 64'(address_exception), 64'(e));
        chk({nm, ".cause"}, 64'(exc_cause), 64'(c));
        chk({nm, ".tval"}, 64'(exc_tval), 64'(t));
        chk({nm, ".cnt"}, 64'(fault_cnt), 64'(exp_cnt));
    endtask

    task automatic idle_inputs();
        exception_sig = 0; mret_sig = 0;
        if_valid = 0; if_addr = 32'h3; mem_valid = 0; mem_we = 0; mem_size = 2'b00; mem_addr = 32'hFFFF_FFFF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        if (exp_cnt < 255) exp_cnt++;
    endtask

    initial begin
        vecs[0]  = mk(0, 32'h0,   1, 0, 2'b10, 32'h0000_07FC, 0, 4'd0, 32'h0);
        vecs[1]  = mk(0, 32'h0,   1, 0, 2'b10, 32'h0000_07FE, 1, MIS ? 4'd4 : 4'd5, 32'h7FE);
        vecs[2]  = mk(0, 32'h0,   1, 1, 2'b00, 32'h0000_0800, 1, 4'd7, 32'h800);
        vecs[3]  = mk(1, 32'h2,   1, 1, 2'b10, 32'h0000_0801, 1, MIS ? 4'd0 : 4'd7, MIS ? 32'h2 : 32'h801);
        vecs[4]  = mk(0, 32'h0,   1, 0, 2'b01, 32'hFFFF_FFFF, 1, MIS ? 4'd4 : 4'd5, 32'hFFFF_FFFF);
        vecs[5]  = mk(1, 32'h900, 0, 0, 2'b00, 32'h0,         1, 4'd1, 32'h900);
        vecs[6]  = mk(0, 32'h0,   1, 1, 2'b01, 32'h0000_07FE, 0, 4'd0, 32'h0);
        vecs[7]  = mk(0, 32'h0,   1, 1, 2'b10, 32'h0000_07FD, 1, MIS ? 4'd6 : 4'd7, 32'h7FD);
        vecs[8]  = mk(0, 32'h0,   1, 0, 2'b00, 32'h0000_07FF, 0, 4'd0, 32'h0);
        vecs[9]  = mk(1, 32'h800, 0, 1, 2'b10, 32'hFFFF_FFF1, 1, 4'd1, 32'h800);
        vecs[10] = mk(0, 32'hFFFF_FFFF, 0, 1, 2'b10, 32'hFFFF_FFF1, 0, 4'd0, 32'h0);
        vecs[11] = mk(0, 32'h0,   1, 0, 2'b11, 32'h0000_07FC, 0, 4'd0, 32'h0);
        vecs[12] = mk(0, 32'h0,   1, 0, 2'b10, 32'hFFFF_FFFC, 1, 4'd5, 32'hFFFF_FFFC);
        vecs[13] = mk(1, 32'h7FD, 0, 0, 2'b00, 32'h0,         MIS, 4'd0, MIS ? 32'h7FD : 32'h0);

        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk_out("reset", 0, 4'd0, 32'h0);

        // Table: present for one cycle, check capture, clear with exception_sig
        for (int i = 0; i < 14; i++) begin
            if_valid = vecs[i].if_v; if_addr = vecs[i].if_a;
            mem_valid = vecs[i].mv; mem_we = vecs[i].mwe; mem_size = vecs[i].msz; mem_addr = vecs[i].ma;
            tick();
            if (vecs[i].exc) bump();
            idle_inputs();
            chk_out($sformatf("vec%0d", i), vecs[i].exc, vecs[i].cause, vecs[i].tval);
            exception_sig = 1;
            tick();
            exception_sig = 0;
            chk_out($sformatf("vec%0d_clr", i), 0, 4'd0, 32'h0);
        end

        // Pending holds first fault; later faults ignored and not counted
        mem_valid = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h800;
        tick(); bump();
        idle_inputs();
        if_valid = 1; if_addr = 32'h900;
        tick();
        chk_out("hold", 1, 4'd7, 32'h800);
        // mret with a same-cycle fault in PENDING, then a fault right after clear
        mret_sig = 1;
        tick();
        idle_inputs();
        chk_out("mret_clr", 0, 4'd0, 32'h0);
        mem_valid = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h1000;
        tick(); bump();
        idle_inputs();
        chk_out("post_clr_cap", 1, 4'd5, 32'h1000);
        mret_sig = 1;
        tick();
        mret_sig = 0;
        chk_out("mret_clr2", 0, 4'd0, 32'h0);

        // exception_sig wins over a same-cycle fault in IDLE
        exception_sig = 1;
        mem_valid = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h1000;
        tick();
        idle_inputs();
        chk_out("exc_prio", 0, 4'd0, 32'h0);
        tick();
        chk_out("exc_prio2", 0, 4'd0, 32'h0);

        // Saturation over 300 fault/clear rounds
        for (int i = 0; i < 300; i++) begin
            mem_valid = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h800;
            tick(); bump();
            idle_inputs();
            exception_sig = 1;
            tick();
            exception_sig = 0;
        end
        chk("sat_model", 64'(exp_cnt), 64'd255);
        chk_out("sat", 0, 4'd0, 32'h0);

        // Reset in mid-PENDING clears everything including the counter
        if_valid = 1; if_addr = 32'h900;
        tick();
        idle_inputs();
        chk_out("sat_pend", 1, 4'd1, 32'h900);
        reset = 1;
        tick();
        reset = 0;
        exp_cnt = 0;
        chk_out("mid_reset", 0, 4'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
